fetch_sequencer: RTL and testbench



---
 rtl/fetch_sequencer.sv | 160 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC, reads the combinational instruction memory
// and presents each instruction to decode through a valid/ready IF/ID register.
module fetch_sequencer #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int unsigned MEM_BYTES = 32'd12
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [63:0] if_pc,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_t;

  localparam logic [64:0] MEM_END = 65'(MEM_BYTES);

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [63:0] if_pc_q, if_pc_d;
  logic        halted_q, halted_d;
  logic        fault_q, fault_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic        transfer_s;
  logic        slot_free_s;
  logic [64:0] pc_plus4_s;
  logic        at_end_s;
  logic        redir_ok_s;
  logic        redir_mis_s;

  // The end-of-memory test is done at 65 bits so a PC near 2^64 cannot wrap under the bound.
  assign transfer_s  = if_valid_q & id_ready;
  assign slot_free_s = ~if_valid_q | id_ready;
  assign pc_plus4_s  = {1'b0, pc_q} + 65'd4;
  assign at_end_s    = (pc_plus4_s > MEM_END);
  assign redir_ok_s  = redirect_valid & ~fault_q;
  assign redir_mis_s = (redirect_pc[1:0] != 2'b00);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an accepted redirect overrides every state transition
  always_comb begin
    state_d = state_q;
    if (redir_ok_s) begin
      state_d = redir_mis_s ? S_HALT : S_RUN;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_RUN;
        S_RUN, S_HOLD: begin
          if (at_end_s) begin
            state_d = S_HALT;
          end else if (slot_free_s) begin
            state_d = S_RUN;
          end else begin
            state_d = S_HOLD;
          end
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output / datapath next values; a redirect flushes the slot and suppresses the count
  always_comb begin
    pc_d          = pc_q;
    if_valid_d    = if_valid_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    halted_d      = halted_q;
    fault_d       = fault_q;
    fetch_count_d = fetch_count_q;
    if (redir_ok_s) begin
      if_valid_d = 1'b0;
      if (redir_mis_s) begin
        halted_d = 1'b1;
        fault_d  = 1'b1;
      end else begin
        pc_d     = redirect_pc;
        halted_d = 1'b0;
      end
    end else begin
      if (transfer_s) begin
        fetch_count_d = fetch_count_q + 32'd1;
      end else begin
        fetch_count_d = fetch_count_q;
      end
      case (state_q)
        S_RUN, S_HOLD: begin
          if (at_end_s) begin
            halted_d   = 1'b1;
            if_valid_d = if_valid_q & ~id_ready;
          end else if (slot_free_s) begin
            if_instr_d = imem_instr;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            pc_d       = pc_plus4_s[63:0];
          end else begin
            if_valid_d = if_valid_q;
          end
        end
        S_HALT:  if_valid_d = if_valid_q & ~id_ready;
        default: pc_d = pc_q;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q          <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_instr_q    <= 32'd0;
      if_pc_q       <= 64'd0;
      halted_q      <= 1'b0;
      fault_q       <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      halted_q      <= halted_d;
      fault_q       <= fault_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios on the 12-byte
// program plus randomized traffic checked against a behavioural fetch model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'd0;
  logic        id_ready = 1'b0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;

  int passed = 0;
  int total  = 0;

  logic [31:0] prog [3] = '{32'h005201B3, 32'h00730133, 32'h005504B3};

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a < 64'd12 && a[1:0] == 2'b00) return prog[a[3:2]];
    else return 32'hDEADBEEF;
  endfunction

  assign imem_instr = mem_word(imem_addr);

  fetch_sequencer #(.RESET_PC(64'h0), .MEM_BYTES(32'd12)) dut (
    .clk(clk), .reset_n(reset_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .halted(halted),
    .fault(fault), .fetch_count(fetch_count)
  );

  // Behavioural model: a fetch pointer, one presentation slot and a few flags.
  logic [63:0] m_pc, m_ipc;
  logic [31:0] m_instr, m_count;
  logic        m_valid, m_halted, m_fault, m_fresh;

  task automatic model_reset();
    m_pc = 64'd0; m_ipc = 64'd0; m_instr = 32'd0; m_count = 32'd0;
    m_valid = 1'b0; m_halted = 1'b0; m_fault = 1'b0; m_fresh = 1'b1;
  endtask

  task automatic model_step(input logic rdy, input logic rv, input logic [63:0] rpc);
    logic xfer;
    xfer = m_valid && rdy;
    if (rv && !m_fault) begin
      m_valid = 1'b0;
      m_fresh = 1'b0;
      if (rpc[1:0] != 2'b00) begin
        m_fault = 1'b1; m_halted = 1'b1;
      end else begin
        m_pc = rpc; m_halted = 1'b0;
      end
    end else begin
      if (xfer) m_count = m_count + 32'd1;
      if (m_fresh) begin
        m_fresh = 1'b0;
      end else if (m_halted) begin
        if (xfer) m_valid = 1'b0;
      end else if ({1'b0, m_pc} + 65'd4 > 65'd12) begin
        m_halted = 1'b1;
        if (xfer) m_valid = 1'b0;
      end else if (!m_valid || rdy) begin
        m_instr = mem_word(m_pc); m_ipc = m_pc; m_valid = 1'b1; m_pc = m_pc + 64'd4;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    redirect_valid = 1'b0; redirect_pc = 64'd0; id_ready = 1'b0;
    @(negedge clk) reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
  endtask

  task automatic test_reset();
    redirect_valid = 1'b0; id_ready = 1'b1;
    @(negedge clk) reset_n = 1'b0;
    #1;
    total++;
    if ({if_valid, if_instr, if_pc, halted, fault, fetch_count, imem_addr} !== {1'b0, 32'd0, 64'd0, 1'b0, 1'b0, 32'd0, 64'd0})
      $display("FAIL reset_state: valid=%0b instr=%h pc=%h halted=%0b fault=%0b count=%0d addr=%h, required all zero",
               if_valid, if_instr, if_pc, halted, fault, fetch_count, imem_addr);
    else passed++;
    @(negedge clk) reset_n = 1'b1;
  endtask

  task automatic test_free_run();
    do_reset();
    id_ready = 1'b1;
    tick();
    total++;
    if (if_valid !== 1'b0) $display("FAIL idle_cycle: if_valid=%0b required 0", if_valid);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (if_valid !== 1'b1 || if_pc !== 64'(4 * i) || if_instr !== prog[i])
        $display("FAIL free_run_%0d: valid=%0b pc=%0d instr=%h required 1/%0d/%h", i, if_valid, if_pc, if_instr, 4 * i, prog[i]);
      else passed++;
    end
    tick();
    total++;
    if (halted !== 1'b1 || if_valid !== 1'b0 || fetch_count !== 32'd3 || imem_addr !== 64'd12)
      $display("FAIL free_run_halt: halted=%0b valid=%0b count=%0d addr=%0d required 1/0/3/12", halted, if_valid, fetch_count, imem_addr);
    else passed++;
  endtask

  task automatic test_back_pressure();
    do_reset();
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (if_valid !== 1'b1 || if_instr !== prog[0] || imem_addr !== 64'd4 || fetch_count !== 32'd0)
        $display("FAIL stall_%0d: valid=%0b instr=%h addr=%0d count=%0d required 1/%h/4/0", i, if_valid, if_instr, imem_addr, fetch_count, prog[0]);
      else passed++;
    end
    id_ready = 1'b1;
    tick();
    total++;
    if (if_valid !== 1'b1 || if_instr !== prog[1] || if_pc !== 64'd4 || fetch_count !== 32'd1)
      $display("FAIL stall_release: valid=%0b instr=%h pc=%0d count=%0d required 1/%h/4/1", if_valid, if_instr, if_pc, fetch_count, prog[1]);
    else passed++;
  endtask

  task automatic test_redirect_flush();
    do_reset();
    id_ready = 1'b1;
    tick();
    tick();
    redirect_valid = 1'b1; redirect_pc = 64'd8;
    tick();
    redirect_valid = 1'b0;
    total++;
    if (if_valid !== 1'b0 || fetch_count !== 32'd0 || imem_addr !== 64'd8)
      $display("FAIL flush_cycle: valid=%0b count=%0d addr=%0d required 0/0/8", if_valid, fetch_count, imem_addr);
    else passed++;
    tick();
    total++;
    if (if_valid !== 1'b1 || if_instr !== prog[2] || if_pc !== 64'd8 || fetch_count !== 32'd0)
      $display("FAIL flush_target: valid=%0b instr=%h pc=%0d count=%0d required 1/%h/8/0", if_valid, if_instr, if_pc, fetch_count, prog[2]);
    else passed++;
    tick();
    total++;
    if (halted !== 1'b1 || fetch_count !== 32'd1)
      $display("FAIL flush_halt: halted=%0b count=%0d required 1/1", halted, fetch_count);
    else passed++;
  endtask

  task automatic test_misaligned();
    do_reset();
    id_ready = 1'b1;
    tick();
    tick();
    redirect_valid = 1'b1; redirect_pc = 64'd6;
    tick();
    total++;
    if (fault !== 1'b1 || halted !== 1'b1 || if_valid !== 1'b0 || imem_addr !== 64'd4 || fetch_count !== 32'd0)
      $display("FAIL misaligned: fault=%0b halted=%0b valid=%0b addr=%0d count=%0d required 1/1/0/4/0", fault, halted, if_valid, imem_addr, fetch_count);
    else passed++;
    redirect_pc = 64'd0;
    tick();
    redirect_valid = 1'b0;
    tick();
    total++;
    if (fault !== 1'b1 || halted !== 1'b1 || if_valid !== 1'b0 || imem_addr !== 64'd4)
      $display("FAIL fault_sticky: fault=%0b halted=%0b valid=%0b addr=%0d required 1/1/0/4", fault, halted, if_valid, imem_addr);
    else passed++;
    do_reset();
    #1;
    total++;
    if (fault !== 1'b0 || halted !== 1'b0)
      $display("FAIL fault_reset: fault=%0b halted=%0b required 0/0", fault, halted);
    else passed++;
  endtask

  task automatic test_restart();
    do_reset();
    id_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    redirect_valid = 1'b1; redirect_pc = 64'd4;
    tick();
    redirect_valid = 1'b0;
    total++;
    if (halted !== 1'b0 || if_valid !== 1'b0 || imem_addr !== 64'd4)
      $display("FAIL restart_redirect: halted=%0b valid=%0b addr=%0d required 0/0/4", halted, if_valid, imem_addr);
    else passed++;
    for (int i = 1; i < 3; i++) begin
      tick();
      total++;
      if (if_valid !== 1'b1 || if_instr !== prog[i] || if_pc !== 64'(4 * i))
        $display("FAIL restart_%0d: valid=%0b instr=%h pc=%0d required 1/%h/%0d", i, if_valid, if_instr, if_pc, prog[i], 4 * i);
      else passed++;
    end
    tick();
    total++;
    if (halted !== 1'b1 || if_valid !== 1'b0 || fetch_count !== 32'd5)
      $display("FAIL restart_halt: halted=%0b valid=%0b count=%0d required 1/0/5", halted, if_valid, fetch_count);
    else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    id_ready = 1'b1;
    tick();
    tick();
    tick();
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (if_valid !== 1'b0 || imem_addr !== 64'd0 || fetch_count !== 32'd0 || halted !== 1'b0)
      $display("FAIL async_reset: valid=%0b addr=%0d count=%0d halted=%0b required 0/0/0/0", if_valid, imem_addr, fetch_count, halted);
    else passed++;
    #1 reset_n = 1'b1;
    tick();
    tick();
    total++;
    if (if_valid !== 1'b1 || if_instr !== prog[0] || if_pc !== 64'd0)
      $display("FAIL async_restart: valid=%0b instr=%h pc=%0d required 1/%h/0", if_valid, if_instr, if_pc, prog[0]);
    else passed++;
  endtask

  task automatic test_random();
    logic [63:0] choices [8] = '{64'd0, 64'd4, 64'd8, 64'd12, 64'd16, 64'hFFFF_FFFF_FFFF_FFFC, 64'd6, 64'd13};
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(0, 24) == 0) begin
        reset_n = 1'b0;
        #1 reset_n = 1'b1;
        model_reset();
      end
      id_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = choices[$urandom_range(0, 7)];
      model_step(id_ready, redirect_valid, redirect_pc);
      tick();
      total++;
      if ({if_valid, if_instr, if_pc, halted, fault, fetch_count, imem_addr} !==
          {m_valid, m_instr, m_ipc, m_halted, m_fault, m_count, m_pc})
        $display("FAIL random_cyc%0d: got v=%0b i=%h p=%h h=%0b f=%0b c=%0d a=%h required v=%0b i=%h p=%h h=%0b f=%0b c=%0d a=%h",
                 cyc, if_valid, if_instr, if_pc, halted, fault, fetch_count, imem_addr,
                 m_valid, m_instr, m_ipc, m_halted, m_fault, m_count, m_pc);
      else passed++;
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_back_pressure();
    test_redirect_flush();
    test_misaligned();
    test_restart();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
